// File: rtl/freq_sequencer_if.sv
// Write port, control and output bundle for freq_sequencer.
// The loop input exists only when FREQ_SEQ_LOOP_EN is defined.
interface freq_sequencer_if #(
  parameter int FREQ_W = 36,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              we;
  logic [1:0]        wsel;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] din;
  logic [ADDR_W:0]   sched_length;
  logic              trigger;
  logic              abort;
`ifdef FREQ_SEQ_LOOP_EN
  logic              loop;
`endif
  logic [FREQ_W-1:0] freq_out;
  logic              step_strobe;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] seg_idx;

`ifdef FREQ_SEQ_LOOP_EN
  modport master (
    output we, wsel, waddr, din,
    output sched_length, trigger, abort, loop,
    input  freq_out, step_strobe, busy, done, seg_idx
  );
  modport slave (
    input  we, wsel, waddr, din,
    input  sched_length, trigger, abort, loop,
    output freq_out, step_strobe, busy, done, seg_idx
  );
`else
  modport master (
    output we, wsel, waddr, din,
    output sched_length, trigger, abort,
    input  freq_out, step_strobe, busy, done, seg_idx
  );
  modport slave (
    input  we, wsel, waddr, din,
    input  sched_length, trigger, abort,
    output freq_out, step_strobe, busy, done, seg_idx
  );
`endif
endinterface

// File: rtl/freq_sequencer.sv
// Multi-segment frequency ramp sequencer driving a DDS tuning word.
// Optional FREQ_SEQ_LOOP_EN replays the schedule while bus.loop is high.
module freq_sequencer #(
  parameter int FREQ_W = 36,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input logic             clk,
  input logic             reset,
  freq_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN
  } state_t;

  logic [DATA_W-1:0] r_mem_f [DEPTH];
  logic [DATA_W-1:0] r_mem_s [DEPTH];
  logic [DATA_W-1:0] r_mem_t [DEPTH];
  logic [DATA_W-1:0] r_mem_h [DEPTH];

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [FREQ_W-1:0] r_freq;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] r_t;
  logic [DATA_W-1:0] r_h;
  logic [DATA_W-1:0] r_tcnt;
  logic [DATA_W-1:0] r_hcnt;
  logic              r_strobe;
  logic              r_busy;
  logic              r_done;

  logic [DATA_W-1:0] w_hlast;
  logic [FREQ_W-1:0] w_step;
  logic              w_seg_end;
  logic              w_last;
  logic              w_tick;
  logic              w_loop;

  // RAM is never reset so a schedule survives a reset pulse
  always_ff @(posedge clk) begin
    if (bus.we) begin
      case (bus.wsel)
        2'd0: r_mem_f[bus.waddr] <= bus.din;
        2'd1: r_mem_s[bus.waddr] <= bus.din;
        2'd2: r_mem_t[bus.waddr] <= bus.din;
        2'd3: r_mem_h[bus.waddr] <= bus.din;
      endcase
    end
  end

  assign w_hlast = (r_h == '0) ? '0
                 : r_h - DATA_W'(1);
  assign w_step  = FREQ_W'($signed(r_s));
  assign w_seg_end = (r_hcnt == w_hlast);
  assign w_last  = ((ADDR_W+1)'(r_idx)
                 == r_len - (ADDR_W+1)'(1));
  assign w_tick  = (r_t != '0)
                && (r_tcnt == r_t - DATA_W'(1));

`ifdef FREQ_SEQ_LOOP_EN
  assign w_loop = bus.loop;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_idx    <= '0;
      r_freq   <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_h      <= '0;
      r_tcnt   <= '0;
      r_hcnt   <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (bus.trigger
                && bus.sched_length != '0) begin
              r_len   <= bus.sched_length;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= FETCH;
            end
          end
          FETCH: begin
            r_freq   <= FREQ_W'(r_mem_f[r_idx]);
            r_s      <= r_mem_s[r_idx];
            r_t      <= r_mem_t[r_idx];
            r_h      <= r_mem_h[r_idx];
            r_tcnt   <= '0;
            r_hcnt   <= '0;
            r_strobe <= 1'b1;
            r_state  <= RUN;
          end
          RUN: begin
            if (w_seg_end) begin
              if (w_last) begin
                r_done <= 1'b1;
                if (w_loop) begin
                  r_idx   <= '0;
                  r_state <= FETCH;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
                end
              end else begin
                r_idx   <= r_idx + ADDR_W'(1);
                r_state <= FETCH;
              end
            end else begin
              r_hcnt <= r_hcnt + DATA_W'(1);
              if (w_tick) begin
                r_freq   <= r_freq + w_step;
                r_tcnt   <= '0;
                r_strobe <= 1'b1;
              end else begin
                r_tcnt <= r_tcnt + DATA_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.freq_out    = r_freq;
  assign bus.step_strobe = r_strobe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.seg_idx     = r_idx;
endmodule

// File: tb/tb_freq_sequencer.sv
// Scoreboard bench for freq_sequencer: per-cycle expected
// {freq_out, step_strobe, busy, done, seg_idx} tuples.
module tb_freq_sequencer;
  localparam int FW = 36;
  localparam int DW = 32;
  localparam int AW = 7;

  typedef struct packed {
    logic [FW-1:0] f;
    logic          s;
    logic          b;
    logic          d;
    logic [AW-1:0] i;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t g;
  exp_t e;

  freq_sequencer_if #(
    .FREQ_W(FW), .DATA_W(DW), .ADDR_W(AW)
  ) bus ();

  freq_sequencer #(
    .FREQ_W(FW), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t sample();
    exp_t r;
    r.f = bus.freq_out;
    r.s = bus.step_strobe;
    r.b = bus.busy;
    r.d = bus.done;
    r.i = bus.seg_idx;
    return r;
  endfunction

  task automatic push(input logic [FW-1:0] f,
                      input logic s, input logic b,
                      input logic d,
                      input logic [AW-1:0] i);
    exp_t x;
    x.f = f; x.s = s; x.b = b; x.d = d; x.i = i;
    q.push_back(x);
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [1:0] sel,
                    input logic [DW-1:0] d);
    bus.we = 1'b1; bus.wsel = sel;
    bus.waddr = a; bus.din = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic prog(input logic [AW-1:0] a,
                      input logic [DW-1:0] f,
                      input logic [DW-1:0] s,
                      input logic [DW-1:0] t,
                      input logic [DW-1:0] h);
    wr(a, 2'd0, f); wr(a, 2'd1, s);
    wr(a, 2'd2, t); wr(a, 2'd3, h);
  endtask

  task automatic test_reset();
    push('0, 0, 0, 0, 0);
    push('0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    g = sample(); e = q.pop_front(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", g, e);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    g = sample(); e = q.pop_front(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset_release got %h want %h", g, e);
    end
  endtask

  task automatic test_single();
    prog(0, 100, 5, 2, 6);
    bus.sched_length = 1;
    bus.trigger = 1'b1;
    push(0,   0, 1, 0, 0);
    push(100, 1, 1, 0, 0);
    push(100, 0, 1, 0, 0);
    push(105, 1, 1, 0, 0);
    push(105, 0, 1, 0, 0);
    push(110, 1, 1, 0, 0);
    push(110, 0, 1, 0, 0);
    push(110, 0, 0, 1, 0);
    push(110, 0, 0, 0, 0);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single c%0d got %h want %h",
                 c, g, e);
      end
    end
  endtask

  task automatic test_two_seg();
    prog(0, 1000, 32'hFFFF_FFFF, 1, 3);
    prog(1, 50, 0, 0, 2);
    bus.sched_length = 2;
    bus.trigger = 1'b1;
    push(110,  0, 1, 0, 0);
    push(1000, 1, 1, 0, 0);
    push(999,  1, 1, 0, 0);
    push(998,  1, 1, 0, 0);
    push(998,  0, 1, 0, 1);
    push(50,   1, 1, 0, 1);
    push(50,   0, 1, 0, 1);
    push(50,   0, 0, 1, 1);
    push(50,   0, 0, 0, 1);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL two_seg c%0d got %h want %h",
                 c, g, e);
      end
    end
  endtask

  // F is only 32 bits wide, so the wrap is reached by stepping down
  task automatic test_wrap();
    prog(0, 1, 32'hFFFF_FFFD, 1, 2);
    bus.sched_length = 1;
    bus.trigger = 1'b1;
    push(50,             0, 1, 0, 0);
    push(1,              1, 1, 0, 0);
    push(36'hF_FFFF_FFFE, 1, 1, 0, 0);
    push(36'hF_FFFF_FFFE, 0, 0, 1, 0);
    push(36'hF_FFFF_FFFE, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL wrap c%0d got %h want %h",
                 c, g, e);
      end
    end
  endtask

  task automatic test_len0_h0();
    bus.sched_length = 0;
    bus.trigger = 1'b1;
    repeat (3) push(36'hF_FFFF_FFFE, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL len0 c%0d got %h want %h",
                 c, g, e);
      end
    end
    bus.trigger = 1'b0;
    prog(0, 7, 0, 0, 0);
    bus.sched_length = 1;
    bus.trigger = 1'b1;
    push(36'hF_FFFF_FFFE, 0, 1, 0, 0);
    push(7, 1, 1, 0, 0);
    push(7, 0, 0, 1, 0);
    push(7, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL h0 c%0d got %h want %h",
                 c, g, e);
      end
    end
  endtask

  task automatic test_abort();
    prog(0, 100, 5, 2, 6);
    bus.sched_length = 1;
    bus.trigger = 1'b1;
    push(7,   0, 1, 0, 0);
    push(100, 1, 1, 0, 0);
    push(100, 0, 1, 0, 0);
    push(105, 1, 1, 0, 0);
    repeat (3) push(105, 0, 0, 0, 0);
    push(105, 0, 1, 0, 0);
    push(100, 1, 1, 0, 0);
    push(100, 0, 1, 0, 0);
    push(105, 1, 1, 0, 0);
    push(105, 0, 1, 0, 0);
    push(110, 1, 1, 0, 0);
    push(110, 0, 1, 0, 0);
    push(110, 0, 0, 1, 0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      bus.abort = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort c%0d got %h want %h",
                 c, g, e);
      end
      if (c == 3) begin
        bus.abort = 1'b1;
        bus.trigger = 1'b1;
      end
      if (c == 6) bus.trigger = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    bus.sched_length = 1;
    bus.trigger = 1'b1;
    push(110, 0, 1, 0, 0);
    push(100, 1, 1, 0, 0);
    push(100, 0, 1, 0, 0);
    push(105, 1, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mid_run c%0d got %h want %h",
                 c, g, e);
      end
    end
    push('0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    g = sample(); e = q.pop_front(); checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL async_reset got %h want %h", g, e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.trigger = 1'b1;
    push(0,   0, 1, 0, 0);
    push(100, 1, 1, 0, 0);
    push(100, 0, 1, 0, 0);
    push(105, 1, 1, 0, 0);
    push(105, 0, 1, 0, 0);
    push(110, 1, 1, 0, 0);
    push(110, 0, 1, 0, 0);
    push(110, 0, 0, 1, 0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ram_kept c%0d got %h want %h",
                 c, g, e);
      end
    end
  endtask

`ifdef FREQ_SEQ_LOOP_EN
  task automatic test_loop();
    prog(0, 10, 0, 0, 1);
    prog(1, 20, 0, 0, 1);
    bus.sched_length = 2;
    bus.loop = 1'b1;
    bus.trigger = 1'b1;
    push(110, 0, 1, 0, 0);
    push(10, 1, 1, 0, 0);
    push(10, 0, 1, 0, 1);
    push(20, 1, 1, 0, 1);
    push(20, 0, 1, 1, 0);
    push(10, 1, 1, 0, 0);
    push(10, 0, 1, 0, 1);
    push(20, 1, 1, 0, 1);
    push(20, 0, 1, 1, 0);
    push(10, 1, 1, 0, 0);
    push(10, 0, 1, 0, 1);
    push(20, 1, 1, 0, 1);
    push(20, 0, 0, 1, 1);
    push(20, 0, 0, 0, 1);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      bus.trigger = 1'b0;
      g = sample(); e = q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL loop c%0d got %h want %h",
                 c, g, e);
      end
      if (c == 8) bus.loop = 1'b0;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.we = 1'b0;
    bus.wsel = '0;
    bus.waddr = '0;
    bus.din = '0;
    bus.sched_length = '0;
    bus.trigger = 1'b0;
    bus.abort = 1'b0;
`ifdef FREQ_SEQ_LOOP_EN
    bus.loop = 1'b0;
`endif
    test_reset();
    test_single();
    test_two_seg();
    test_wrap();
    test_len0_h0();
    test_abort();
    test_reset_mid();
`ifdef FREQ_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
